instr_encoder: RTL and testbench
================================

# instr_encoder

Encodes symbolic instruction commands into 32-bit MIPS machine words for the supported subset: addu, subu, sll, jr, jalr, ori, lui, sltiu, lw, sw, beq, j, jal and nop. Encoded words are buffered in a small FIFO and streamed out with their byte addresses. The block feeds instruction memory during self-load and bench program generation, and is the inverse of the stage controllers' opcode/funct decode. Every word it emits must decode back to the same operation.

## Interface
- DEPTH, 4: output FIFO depth in words; power of two, ≥2.
- BASE_ADDR, 32'h0000_3000: byte address of the first emitted word.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  4  0 addu, 1 subu, 2 sll, 3 jr, 4 jalr, 5 ori, 6 lui, 7 sltiu, 8 lw, 9 sw, 10 beq, 11 j, 12 jal, 13 nop, 14–15 illegal.
- cmd_rs, cmd_rt, cmd_rd, cmd_shamt  in  5 each  register/shift fields.
- cmd_imm  in  16  immediate (I-type).
- cmd_target  in  26  jump target (J-type).
- out_valid  out  1  head word valid.
- out_ready  in  1  consumer takes head word when out_valid & out_ready.
- out_instr  out  32  head word.
- out_addr  out  32  byte address of head word.
- err  out  1  sticky illegal-op flag.

## Operation
- **R-type** = {6'b000000, rs, rt, rd, shamt, funct}.
  - addu: funct 100001, shamt 0.
  - subu: funct 100011, shamt 0.
  - sll: funct 000000, rs 0.
  - jr: {rs, 15'b0, 001000}.
  - jalr: {rs, 5'b0, rd, 5'b0, 001001}.
- **I-type** = {op, rs, rt, imm}.
  - Opcodes: ori 001101, sltiu 001011, lw 100011, sw 101011, beq 000100, lui 001111.
  - lui: rs forced to 0.
- **J-type** = {op, target}; j 000010, jal 000011.
- nop = 32'h0000_0000.
- Every field not used by the selected format is forced to zero, whatever the cmd_* input holds.
- **Illegal op (14–15):**
  - The command is accepted (handshake completes).
  - No word is pushed.
  - err is set on the next cycle and stays set until reset.
- **FSM states:**
  - IDLE: cmd_ready = !fifo_full.
  - SLOT: exists only with the delay-slot feature (see Configuration). cmd_ready = 0.
    - Pushes a nop when !fifo_full, then returns to IDLE.
    - Stays in SLOT while the FIFO is full.
- **FIFO:**
  - DEPTH entries; count width clog2(DEPTH)+1.
  - Push and pop in the same cycle are legal when not empty; count is unchanged.
  - When full, the push is blocked by cmd_ready = 0. cmd_ready does not depend on out_ready in the same cycle.
- **Address counter:**
  - Holds the address of the head word.
  - Advances by 4 on each output handshake.
  - Wraps modulo 2^32 (32'hFFFF_FFFC + 4 → 0).

## Timing
- Values after reset: cmd_ready 1, out_valid 0, out_instr 0, out_addr BASE_ADDR, err 0, FIFO empty, FSM in IDLE.
- A command accepted in cycle N makes its word visible (out_valid = 1) in cycle N+1, provided the FIFO was empty.
- The delay-slot nop is pushed in N+1 at the earliest, so it is visible at the head in N+2 at the earliest.
- out_instr and out_addr are stable while out_valid & !out_ready.
- Throughput: one word per cycle in each direction.
- A reset assertion mid-stream takes effect immediately:
  - The FIFO is flushed.
  - A pending SLOT nop is dropped.
  - The address counter returns to BASE_ADDR.

## Configuration
- **Macro ENC_DELAY_SLOT_EN.**
- When defined:
  - Each accepted beq, j, jal, jr or jalr moves the FSM to SLOT.
  - Exactly one nop is inserted after the branch word; it consumes the next address.
- When undefined:
  - The SLOT state is not synthesized and the FSM is IDLE only.
  - Branches emit a single word; no nops are inserted.

## Test plan
- Encodings in order, out_ready = 1:
  - addu rs1 rt2 rd3 → 32'h0022_1821 @ 32'h3000.
  - ori rs0 rt8 imm 1234 → 32'h3408_1234 @ 32'h3004.
  - lui rs=7 rt1 imm ABCD → 32'h3C01_ABCD (rs masked).
  - lw rs29 rt9 imm 4 → 32'h8FA9_0004.
  - sw rs29 rt9 imm 4 → 32'hAFA9_0004.
- Back-pressure: out_ready = 0 while 5 commands are offered → 4 accepted, then cmd_ready = 0; head stays 32'h0022_1821 @ 32'h3000 until out_ready rises.
- Delay slot, macro defined: beq rs1 rt2 imm 3, then j 0xC00 → words 32'h1022_0003, 0, 32'h0800_0C00, 0 at 3000/3004/3008/300C; cmd_ready is 0 in each SLOT cycle. Macro undefined: only the two branch words are emitted.
- Illegal op 15 → handshake completes, no word pushed, err = 1 on the next cycle; subsequent valid commands still encode normally.
- Reset mid-stream with 3 words queued → out_valid = 0, out_addr = 32'h3000 immediately; the next command emits @ 32'h3000.
- Wrap-around: BASE_ADDR = 32'hFFFF_FFFC, two nops → addresses FFFF_FFFC then 0000_0000.

Source files
------------

// File: rtl/instr_encoder_if.sv
// instr_encoder_if
//   Command and output-stream bundle for instr_encoder.
//   Command side : cmd_valid/cmd_ready handshake, cmd_op, cmd_rs, cmd_rt,
//                  cmd_rd, cmd_shamt, cmd_imm, cmd_target.
//   Output side  : out_valid/out_ready handshake, out_instr, out_addr.
//   Status       : err (sticky illegal-op flag).
//   master drives commands and consumes words; slave is the encoder.
interface instr_encoder_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [4:0]  cmd_rs;
  logic [4:0]  cmd_rt;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_shamt;
  logic [15:0] cmd_imm;
  logic [25:0] cmd_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;

  modport master (
    output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm,
           cmd_target, out_ready,
    input  cmd_ready, out_valid, out_instr, out_addr, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm,
           cmd_target, out_ready,
    output cmd_ready, out_valid, out_instr, out_addr, err
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder
//   Encodes symbolic commands (addu, subu, sll, jr, jalr, ori, lui, sltiu,
//   lw, sw, beq, j, jal, nop) into 32-bit MIPS words, buffers them in a
//   DEPTH-entry FIFO and streams them out with their byte addresses.
//   Ports: clk, reset_n (async, active-low), bus (instr_encoder_if.slave).
//   Parameters: DEPTH (power of two, >= 2), BASE_ADDR (address of 1st word).
//   Optional feature: define ENC_DELAY_SLOT_EN to insert one nop after every
//   accepted beq/j/jal/jr/jalr (adds the SLOT state).
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic           clk,
  input  logic           reset_n,
  instr_encoder_if.slave bus
);
  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam int unsigned   CW       = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

`ifdef ENC_DELAY_SLOT_EN
  typedef enum logic [0:0] {IDLE = 1'b0, SLOT = 1'b1} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0} state_t;
`endif

  state_t        state_r, state_s;
  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   addr_r;
  logic          err_r;
  logic          full_s, out_valid_s, pop_s;
  logic          push_s, cmd_ready_s, illegal_s;
  logic [31:0]   push_data_s;

  // Fields outside the selected format are forced to zero; nop and the
  // illegal codes map to the all-zero word (illegal words are never pushed).
  function automatic logic [31:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  rs, rt, rd, shamt,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = 32'h0000_0000;
    case (op)
      4'd0:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100001};
      4'd1:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100011};
      4'd2:    w = {6'b000000, 5'b00000, rt, rd, shamt, 6'b000000};
      4'd3:    w = {6'b000000, rs, 15'b0, 6'b001000};
      4'd4:    w = {6'b000000, rs, 5'b00000, rd, 5'b00000, 6'b001001};
      4'd5:    w = {6'b001101, rs, rt, imm};
      4'd6:    w = {6'b001111, 5'b00000, rt, imm};
      4'd7:    w = {6'b001011, rs, rt, imm};
      4'd8:    w = {6'b100011, rs, rt, imm};
      4'd9:    w = {6'b101011, rs, rt, imm};
      4'd10:   w = {6'b000100, rs, rt, imm};
      4'd11:   w = {6'b000010, target};
      4'd12:   w = {6'b000011, target};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  assign full_s      = (count_r == CNT_FULL);
  assign out_valid_s = (count_r != {CW{1'b0}});
  assign pop_s       = out_valid_s & bus.out_ready;

  // Next-state and push control; cmd_ready depends only on registered state.
  always_comb begin
    state_s     = state_r;
    push_s      = 1'b0;
    push_data_s = 32'h0000_0000;
    cmd_ready_s = 1'b0;
    illegal_s   = 1'b0;
    case (state_r)
      IDLE: begin
        cmd_ready_s = !full_s;
        if (bus.cmd_valid && !full_s) begin
          if (bus.cmd_op >= 4'd14) begin
            illegal_s = 1'b1;
          end else begin
            push_s      = 1'b1;
            push_data_s = encode(bus.cmd_op, bus.cmd_rs, bus.cmd_rt, bus.cmd_rd,
                                 bus.cmd_shamt, bus.cmd_imm, bus.cmd_target);
`ifdef ENC_DELAY_SLOT_EN
            if (bus.cmd_op inside {4'd3, 4'd4, 4'd10, 4'd11, 4'd12}) begin
              state_s = SLOT;
            end else begin
              state_s = IDLE;
            end
`endif
          end
        end else begin
          state_s = IDLE;
        end
      end
`ifdef ENC_DELAY_SLOT_EN
      SLOT: begin
        // Hold here until there is room for the delay-slot nop.
        if (!full_s) begin
          push_s      = 1'b1;
          push_data_s = 32'h0000_0000;
          state_s     = IDLE;
        end else begin
          state_s = SLOT;
        end
      end
`endif
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FIFO storage, pointers, occupancy and head address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      addr_r   <= BASE_ADDR;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        // Natural 32-bit overflow gives the required modulo-2^32 wrap.
        addr_r   <= addr_r + 32'd4;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky illegal-op flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_r <= 1'b0;
    end else if (illegal_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_instr = mem_r[rd_ptr_r];
  assign bus.out_addr  = addr_r;
  assign bus.err       = err_r;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
//   Self-checking bench for instr_encoder: a queue-based reference model
//   tracks expected words, addresses and err; a compare process checks the
//   DUT every negedge. Directed sections pin the model with literal words,
//   then a randomized phase runs against the model. A second instance with
//   BASE_ADDR = 32'hFFFF_FFFC exercises the address wrap.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if bus ();
  instr_encoder_if bus_w ();

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset_n(reset_n), .bus(bus_w)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr = BASE;
  logic        exp_err = 1'b0;
  logic [63:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference encoding built from opcode/funct numbers and field shifts.
  function automatic logic [31:0] ref_enc(input logic [31:0] op, rs, rt, rd, sh, imm, tgt);
    case (op)
      32'd0:   return (rs << 21) | (rt << 16) | (rd << 11) | 32'd33;
      32'd1:   return (rs << 21) | (rt << 16) | (rd << 11) | 32'd35;
      32'd2:   return (rt << 16) | (rd << 11) | (sh << 6);
      32'd3:   return (rs << 21) | 32'd8;
      32'd4:   return (rs << 21) | (rd << 11) | 32'd9;
      32'd5:   return (32'd13 << 26) | (rs << 21) | (rt << 16) | imm;
      32'd6:   return (32'd15 << 26) | (rt << 16) | imm;
      32'd7:   return (32'd11 << 26) | (rs << 21) | (rt << 16) | imm;
      32'd8:   return (32'd35 << 26) | (rs << 21) | (rt << 16) | imm;
      32'd9:   return (32'd43 << 26) | (rs << 21) | (rt << 16) | imm;
      32'd10:  return (32'd4 << 26) | (rs << 21) | (rt << 16) | imm;
      32'd11:  return (32'd2 << 26) | tgt;
      32'd12:  return (32'd3 << 26) | tgt;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_branch(input logic [3:0] op);
    return (op == 4'd3) || (op == 4'd4) || (op == 4'd10) || (op == 4'd11) || (op == 4'd12);
  endfunction

  // Model update on each handshake seen at the clock edge.
  always @(posedge clk) begin
    if (reset_n) begin
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back({bus.out_instr, bus.out_addr});
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        exp_addr = exp_addr + 32'd4;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (bus.cmd_op >= 4'd14) begin
          exp_err = 1'b1;
        end else begin
          exp_q.push_back(ref_enc(32'(bus.cmd_op), 32'(bus.cmd_rs), 32'(bus.cmd_rt),
                                  32'(bus.cmd_rd), 32'(bus.cmd_shamt), 32'(bus.cmd_imm),
                                  32'(bus.cmd_target)));
`ifdef ENC_DELAY_SLOT_EN
          if (is_branch(bus.cmd_op)) exp_q.push_back(32'd0);
`endif
        end
      end
    end
  end

  // Compare DUT outputs against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (reset_n) begin
      check("err", 32'(bus.err), 32'(exp_err));
`ifndef ENC_DELAY_SLOT_EN
      check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      check("cmd_ready", 32'(bus.cmd_ready), 32'(exp_q.size() < DEPTH));
`endif
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(bus.out_valid), 32'd0);
        end else begin
          check("out_instr", bus.out_instr, exp_q[0]);
          check("out_addr", bus.out_addr, exp_addr);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    exp_q.delete();
    exp_addr = BASE;
    exp_err = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Offer one command until accepted or the cycle budget runs out.
  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input int budget, output bit acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op; bus.cmd_rs = rs; bus.cmd_rt = rt; bus.cmd_rd = rd;
    bus.cmd_shamt = sh; bus.cmd_imm = imm; bus.cmd_target = tgt;
    acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) begin
      @(posedge clk);
      if (bus.cmd_ready) acc = 1'b1;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
  endtask

  logic [31:0] enc_lit [5] = '{32'h0022_1821, 32'h3408_1234, 32'h3C01_ABCD,
                               32'h8FA9_0004, 32'hAFA9_0004};
  logic [3:0]  enc_op  [5] = '{4'd0, 4'd5, 4'd6, 4'd8, 4'd9};
  logic [4:0]  enc_rs  [5] = '{5'd1, 5'd0, 5'd7, 5'd29, 5'd29};
  logic [4:0]  enc_rt  [5] = '{5'd2, 5'd8, 5'd1, 5'd9, 5'd9};
  logic [4:0]  enc_rd  [5] = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd0};
  logic [15:0] enc_imm [5] = '{16'h0, 16'h1234, 16'hABCD, 16'h4, 16'h4};

  initial begin
    bit acc;
    bus.cmd_valid = 1'b0; bus.cmd_op = 4'd0; bus.cmd_rs = 5'd0; bus.cmd_rt = 5'd0;
    bus.cmd_rd = 5'd0; bus.cmd_shamt = 5'd0; bus.cmd_imm = 16'd0; bus.cmd_target = 26'd0;
    bus.out_ready = 1'b0;
    bus_w.cmd_valid = 1'b0; bus_w.cmd_op = 4'd13; bus_w.cmd_rs = 5'd0; bus_w.cmd_rt = 5'd0;
    bus_w.cmd_rd = 5'd0; bus_w.cmd_shamt = 5'd0; bus_w.cmd_imm = 16'd0; bus_w.cmd_target = 26'd0;
    bus_w.out_ready = 1'b1;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_addr", bus.out_addr, 32'h0000_3000);
    check("rst_err", 32'(bus.err), 32'd0);
    reset_n = 1'b1;

    // Address wrap on the second instance: two nops.
    @(negedge clk);
    bus_w.cmd_valid = 1'b1;
    @(negedge clk);
    check("wrap_valid0", 32'(bus_w.out_valid), 32'd1);
    check("wrap_addr0", bus_w.out_addr, 32'hFFFF_FFFC);
    check("wrap_instr0", bus_w.out_instr, 32'd0);
    @(negedge clk);
    bus_w.cmd_valid = 1'b0;
    check("wrap_valid1", 32'(bus_w.out_valid), 32'd1);
    check("wrap_addr1", bus_w.out_addr, 32'h0000_0000);

    // Encodings in order with out_ready high.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(enc_op[i], enc_rs[i], enc_rt[i], enc_rd[i], 5'd0, enc_imm[i], 26'd0, 5, acc);
      check("enc_accept", 32'(acc), 32'd1);
      check("enc_model", ref_enc(32'(enc_op[i]), 32'(enc_rs[i]), 32'(enc_rt[i]),
                                 32'(enc_rd[i]), 32'd0, 32'(enc_imm[i]), 32'd0), enc_lit[i]);
      check("enc_word", bus.out_instr, enc_lit[i]);
      check("enc_addr", bus.out_addr, 32'h0000_3000 + 32'(4 * i));
    end
    repeat (3) @(negedge clk);

    // Back-pressure: only DEPTH commands fit.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(enc_op[i], enc_rs[i], enc_rt[i], enc_rd[i], 5'd0, enc_imm[i], 26'd0, 5, acc);
      check("bp_accept", 32'(acc), 32'd1);
    end
    send(enc_op[4], enc_rs[4], enc_rt[4], enc_rd[4], 5'd0, enc_imm[4], 26'd0, 3, acc);
    check("bp_5th_blocked", 32'(acc), 32'd0);
    check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("bp_head_word", bus.out_instr, 32'h0022_1821);
    check("bp_head_addr", bus.out_addr, 32'h0000_3000);
    bus.out_ready = 1'b1;
    send(enc_op[4], enc_rs[4], enc_rt[4], enc_rd[4], 5'd0, enc_imm[4], 26'd0, 10, acc);
    check("bp_5th_accept", 32'(acc), 32'd1);
    repeat (8) @(negedge clk);

    // Reset mid-stream with three words queued.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(enc_op[i], enc_rs[i], enc_rt[i], enc_rd[i], 5'd0, enc_imm[i], 26'd0, 5, acc);
    #2 reset_n = 1'b0;
    exp_q.delete(); exp_addr = BASE; exp_err = 1'b0;
    #1;
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_out_addr", bus.out_addr, 32'h0000_3000);
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 5, acc);
    check("mrst_next_addr", bus.out_addr, 32'h0000_3000);
    check("mrst_next_word", bus.out_instr, 32'h0022_1821);
    repeat (2) @(negedge clk);

    // Illegal op: accepted, nothing pushed, err next cycle, then normal encoding.
    do_reset();
    send(4'd15, 5'd3, 5'd4, 5'd5, 5'd6, 16'h7777, 26'h1, 5, acc);
    check("ill_accept", 32'(acc), 32'd1);
    check("ill_err", 32'(bus.err), 32'd1);
    check("ill_no_word", 32'(bus.out_valid), 32'd0);
    send(4'd5, 5'd0, 5'd8, 5'd0, 5'd0, 16'h1234, 26'd0, 5, acc);
    check("ill_after_word", bus.out_instr, 32'h3408_1234);
    check("ill_after_addr", bus.out_addr, 32'h0000_3000);
    repeat (2) @(negedge clk);

    // Branch sequence: beq then j.
    do_reset();
    got_q.delete();
    send(4'd10, 5'd1, 5'd2, 5'd0, 5'd0, 16'd3, 26'd0, 5, acc);
`ifdef ENC_DELAY_SLOT_EN
    check("slot_cmd_ready", 32'(bus.cmd_ready), 32'd0);
`endif
    send(4'd11, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'hC00, 5, acc);
`ifdef ENC_DELAY_SLOT_EN
    check("slot_cmd_ready2", 32'(bus.cmd_ready), 32'd0);
`endif
    repeat (6) @(negedge clk);
`ifdef ENC_DELAY_SLOT_EN
    begin
      logic [63:0] br_exp [4] = '{{32'h1022_0003, 32'h3000}, {32'h0, 32'h3004},
                                  {32'h0800_0C00, 32'h3008}, {32'h0, 32'h300C}};
      check("br_count", 32'(got_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
        check("br_word", got_q[i][63:32], br_exp[i][63:32]);
        check("br_addr", got_q[i][31:0], br_exp[i][31:0]);
      end
    end
`else
    begin
      logic [63:0] br_exp [2] = '{{32'h1022_0003, 32'h3000}, {32'h0800_0C00, 32'h3004}};
      check("br_count", 32'(got_q.size()), 32'd2);
      for (int i = 0; i < 2 && i < got_q.size(); i++) begin
        check("br_word", got_q[i][63:32], br_exp[i][63:32]);
        check("br_addr", got_q[i][31:0], br_exp[i][31:0]);
      end
    end
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      bus.cmd_valid  = 1'($urandom_range(0, 3) != 0);
      bus.cmd_op     = 4'($urandom_range(0, 15));
      bus.cmd_rs     = 5'($urandom);
      bus.cmd_rt     = 5'($urandom);
      bus.cmd_rd     = 5'($urandom);
      bus.cmd_shamt  = 5'($urandom);
      bus.cmd_imm    = 16'($urandom);
      bus.cmd_target = 26'($urandom);
      bus.out_ready  = 1'($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3 * DEPTH) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
